// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and digit limits for the stopwatch controller and its BCD digit counters.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t min;
    bcd_t sec_tens;
    bcd_t sec_ones;
    bcd_t tenths;
  } count_t;

  localparam bcd_t TENTHS_MAX   = 4'd9;
  localparam bcd_t SEC_ONES_MAX = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit_counter.sv
// Single BCD digit counting 0..MAX; carry is combinational so a ripple-enable chain settles in one cycle.
module bcd_digit_counter
  import stopwatch_ctrl_pkg::*;
#(
  parameter bcd_t MAX = 4'd9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] q,
  output logic       carry
);

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      q <= '0;
    end else if (en) begin
      q <= (q == MAX) ? '0 : q + 4'd1;
    end
  end

  assign carry = en && (q == MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: IDLE/RUN/PAUSE/LAP FSM over a four-digit BCD count (M:SS.t) with lap freeze
// and sticky saturation at MAX_MIN:59.9.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned MAX_MIN = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] digit_tenths,
  output logic [3:0] digit_sec_ones,
  output logic [3:0] digit_sec_tens,
  output logic [3:0] digit_min,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);

  localparam bcd_t MIN_MAX = bcd_t'(MAX_MIN);

  state_t state;
  count_t live;
  count_t latched;
  count_t shown;
  logic   counting;
  logic   at_max;
  logic   step;
  logic   sat;
  logic   inc;
  logic   c_tenths;
  logic   c_sec_ones;
  logic   c_sec_tens;
  logic   c_min;

  assign counting = (state == RUN) || (state == LAP);
  assign at_max   = (live.min == MIN_MAX) && (live.sec_tens == SEC_TENS_MAX) &&
                    (live.sec_ones == SEC_ONES_MAX) && (live.tenths == TENTHS_MAX);
  assign step     = tick && counting && !clear;
  assign sat      = step && at_max;
  assign inc      = step && !at_max;

  bcd_digit_counter #(.MAX(TENTHS_MAX)) u_tenths (
    .clock(clock), .reset(reset), .clr(clear), .en(inc),
    .q(live.tenths), .carry(c_tenths)
  );

  bcd_digit_counter #(.MAX(SEC_ONES_MAX)) u_sec_ones (
    .clock(clock), .reset(reset), .clr(clear), .en(c_tenths),
    .q(live.sec_ones), .carry(c_sec_ones)
  );

  bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clock(clock), .reset(reset), .clr(clear), .en(c_sec_ones),
    .q(live.sec_tens), .carry(c_sec_tens)
  );

  bcd_digit_counter #(.MAX(MIN_MAX)) u_min (
    .clock(clock), .reset(reset), .clr(clear), .en(c_sec_tens),
    .q(live.min), .carry(c_min)
  );

  // The tick that would wrap the minutes is gated off by at_max, so c_min should never rise;
  // it is folded into the saturation condition so a wrap can only ever end in overflow.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state      <= IDLE;
      running    <= 1'b0;
      lap_active <= 1'b0;
      overflow   <= 1'b0;
      latched    <= '0;
    end else if (sat || c_min) begin
      state      <= PAUSE;
      running    <= 1'b0;
      lap_active <= 1'b0;
      overflow   <= 1'b1;
    end else begin
      case (state)
        IDLE, PAUSE: begin
          if (start_stop && !overflow) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (start_stop) begin
            state   <= PAUSE;
            running <= 1'b0;
          end else if (lap) begin
            state      <= LAP;
            lap_active <= 1'b1;
            latched    <= live;
          end
        end
        LAP: begin
          if (start_stop) begin
            state      <= PAUSE;
            running    <= 1'b0;
            lap_active <= 1'b0;
          end else if (lap) begin
            state      <= RUN;
            lap_active <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          running    <= 1'b0;
          lap_active <= 1'b0;
        end
      endcase
    end
  end

  assign shown          = lap_active ? latched : live;
  assign digit_tenths   = shown.tenths;
  assign digit_sec_ones = shown.sec_ones;
  assign digit_sec_tens = shown.sec_tens;
  assign digit_min      = shown.min;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: vector table, directed corner sequences and random stimulus against a
// tenths-of-a-second arithmetic model, on a MAX_MIN=9 and a MAX_MIN=1 instance sharing inputs.
module tb_stopwatch_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic tick = 1'b0;
  logic start_stop = 1'b0;
  logic clear = 1'b0;
  logic lap = 1'b0;

  logic [3:0] d_t[2];
  logic [3:0] d_so[2];
  logic [3:0] d_st[2];
  logic [3:0] d_m[2];
  logic       o_run[2];
  logic       o_lap[2];
  logic       o_ovf[2];

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  stopwatch_ctrl dut (
    .clock(clock), .reset(reset), .tick(tick), .start_stop(start_stop), .clear(clear), .lap(lap),
    .digit_tenths(d_t[0]), .digit_sec_ones(d_so[0]), .digit_sec_tens(d_st[0]), .digit_min(d_m[0]),
    .running(o_run[0]), .lap_active(o_lap[0]), .overflow(o_ovf[0])
  );

  stopwatch_ctrl #(.MAX_MIN(1)) dut1 (
    .clock(clock), .reset(reset), .tick(tick), .start_stop(start_stop), .clear(clear), .lap(lap),
    .digit_tenths(d_t[1]), .digit_sec_ones(d_so[1]), .digit_sec_tens(d_st[1]), .digit_min(d_m[1]),
    .running(o_run[1]), .lap_active(o_lap[1]), .overflow(o_ovf[1])
  );

  // Model: count in tenths of a second, limit is the largest representable value.
  int m_cnt[2];
  int m_lat[2];
  bit m_run[2];
  bit m_lap[2];
  bit m_ovf[2];
  int m_lim[2] = '{9 * 600 + 599, 1 * 600 + 599};

  function automatic logic [15:0] to_bcd(input int c);
    logic [3:0] mn, st, so, te;
    mn = 4'(c / 600);
    st = 4'((c / 100) % 6);
    so = 4'((c / 10) % 10);
    te = 4'(c % 10);
    return {mn, st, so, te};
  endfunction

  function automatic logic [15:0] act_dig(input int k);
    return {d_m[k], d_st[k], d_so[k], d_t[k]};
  endfunction

  task automatic model_step(input int k);
    int old;
    bit inc;
    if (reset || clear) begin
      m_cnt[k] = 0; m_lat[k] = 0; m_run[k] = 0; m_lap[k] = 0; m_ovf[k] = 0;
    end else begin
      old = m_cnt[k];
      inc = tick && m_run[k];
      if (inc && old == m_lim[k]) begin
        m_ovf[k] = 1; m_run[k] = 0; m_lap[k] = 0;
      end else begin
        if (inc) m_cnt[k] = old + 1;
        if (start_stop) begin
          if (m_run[k]) begin
            m_run[k] = 0; m_lap[k] = 0;
          end else if (!m_ovf[k]) begin
            m_run[k] = 1;
          end
        end else if (lap && m_run[k]) begin
          if (m_lap[k]) m_lap[k] = 0;
          else begin
            m_lap[k] = 1; m_lat[k] = old;
          end
        end
      end
    end
  endtask

  task automatic check_model(input int k);
    logic [15:0] exp_dig;
    exp_dig = to_bcd(m_lap[k] ? m_lat[k] : m_cnt[k]);
    tests++;
    if (act_dig(k) !== exp_dig || o_run[k] !== m_run[k] || o_lap[k] !== m_lap[k] ||
        o_ovf[k] !== m_ovf[k]) begin
      fails++;
      $display("FAIL model[%0d] t=%0t: got dig=%h run=%b lap=%b ovf=%b, expected dig=%h run=%b lap=%b ovf=%b",
               k, $time, act_dig(k), o_run[k], o_lap[k], o_ovf[k], exp_dig, m_run[k], m_lap[k], m_ovf[k]);
    end
  endtask

  task automatic check_exp(input string name, input int k, input logic [15:0] dig,
                           input bit r, input bit la, input bit o);
    tests++;
    if (act_dig(k) !== dig || o_run[k] !== r || o_lap[k] !== la || o_ovf[k] !== o) begin
      fails++;
      $display("FAIL %s[%0d]: got dig=%h run=%b lap=%b ovf=%b, expected dig=%h run=%b lap=%b ovf=%b",
               name, k, act_dig(k), o_run[k], o_lap[k], o_ovf[k], dig, r, la, o);
    end
  endtask

  task automatic cycle(input bit r, input bit s, input bit c, input bit l, input bit t);
    reset = r; start_stop = s; clear = c; lap = l; tick = t;
    @(posedge clock);
    model_step(0);
    model_step(1);
    @(negedge clock);
    check_model(0);
    check_model(1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 1);
  endtask

  typedef struct {
    bit r, s, c, l, t;
    logic [15:0] dig;
    bit run, la, ovf;
  } vec_t;

  vec_t tbl[20];

  initial begin
    //            r  s  c  l  t  digits    run la ovf
    tbl[0]  = '{1, 0, 0, 0, 0, 16'h0000, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 1, 0, 16'h0000, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 1, 16'h0000, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 0, 16'h0000, 1, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 1, 16'h0001, 1, 0, 0};
    tbl[5]  = '{0, 0, 0, 1, 1, 16'h0001, 1, 1, 0};
    tbl[6]  = '{0, 0, 0, 0, 1, 16'h0001, 1, 1, 0};
    tbl[7]  = '{0, 1, 0, 1, 0, 16'h0003, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 1, 16'h0003, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 1, 0, 16'h0003, 0, 0, 0};
    tbl[10] = '{0, 1, 0, 0, 1, 16'h0003, 1, 0, 0};
    tbl[11] = '{0, 1, 0, 0, 1, 16'h0004, 0, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 1, 16'h0004, 0, 0, 0};
    tbl[13] = '{0, 1, 0, 0, 0, 16'h0004, 1, 0, 0};
    tbl[14] = '{0, 1, 1, 0, 1, 16'h0000, 0, 0, 0};
    tbl[15] = '{0, 1, 0, 0, 0, 16'h0000, 1, 0, 0};
    tbl[16] = '{0, 0, 0, 0, 1, 16'h0001, 1, 0, 0};
    tbl[17] = '{0, 0, 0, 1, 0, 16'h0001, 1, 1, 0};
    tbl[18] = '{1, 0, 0, 0, 1, 16'h0000, 0, 0, 0};
    tbl[19] = '{0, 0, 0, 0, 1, 16'h0000, 0, 0, 0};

    foreach (m_cnt[k]) begin
      m_cnt[k] = 0; m_lat[k] = 0; m_run[k] = 0; m_lap[k] = 0; m_ovf[k] = 0;
    end

    for (int i = 0; i < 20; i++) begin
      cycle(tbl[i].r, tbl[i].s, tbl[i].c, tbl[i].l, tbl[i].t);
      check_exp($sformatf("vec%0d", i), 0, tbl[i].dig, tbl[i].run, tbl[i].la, tbl[i].ovf);
    end

    // 25 ticks, then carry through every digit at 0:59.9
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    ticks(25);
    check_exp("run_2_5", 0, 16'h0025, 1, 0, 0);
    ticks(574);
    check_exp("at_59_9", 0, 16'h0599, 1, 0, 0);
    ticks(1);
    check_exp("carry_1_00", 0, 16'h1000, 1, 0, 0);

    // lap freeze and release
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    ticks(12);
    cycle(0, 0, 0, 1, 0);
    ticks(10);
    check_exp("lap_frozen", 0, 16'h0012, 1, 1, 0);
    cycle(0, 0, 0, 1, 0);
    check_exp("lap_release", 0, 16'h0022, 1, 0, 0);

    // saturation on the MAX_MIN=1 instance
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    ticks(1199);
    check_exp("pre_sat", 1, 16'h1599, 1, 0, 0);
    ticks(1);
    check_exp("sat", 1, 16'h1599, 0, 0, 1);
    cycle(0, 1, 0, 0, 0);
    check_exp("sat_ss_ignored", 1, 16'h1599, 0, 0, 1);
    ticks(3);
    check_exp("sat_hold", 1, 16'h1599, 0, 0, 1);
    cycle(0, 0, 1, 0, 0);
    check_exp("sat_clear", 1, 16'h0000, 0, 0, 0);
    cycle(0, 1, 0, 0, 1);
    check_exp("clear_to_idle", 1, 16'h0000, 1, 0, 0);

    // clear priority in RUN, reset mid-LAP
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    ticks(3);
    cycle(0, 1, 1, 1, 1);
    check_exp("clear_prio", 0, 16'h0000, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    ticks(4);
    cycle(0, 0, 0, 1, 0);
    ticks(3);
    check_exp("in_lap", 0, 16'h0004, 1, 1, 0);
    cycle(1, 0, 0, 0, 1);
    check_exp("reset_mid_lap", 0, 16'h0000, 0, 0, 0);

    // random stimulus; second phase clears rarely so the MAX_MIN=1 instance can saturate
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(499) == 0, $urandom_range(15) == 0, $urandom_range(199) == 0,
            $urandom_range(7) == 0, $urandom_range(1) == 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 3000; i++)
      cycle(1'b0, $urandom_range(299) == 0, $urandom_range(4999) == 0,
            $urandom_range(31) == 0, $urandom_range(3) != 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter MAX_MIN, default 9: maximum minutes digit value (1..9).
REQ-002 clock  input  1  system clock, 100 MHz.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 tick  input  1  one-cycle enable pulse, one per 100 ms, from the 100 ms divider.
REQ-005 start_stop  input  1  one-cycle debounced pulse; toggles run/pause.
REQ-006 clear  input  1  one-cycle pulse; zeroes the count and returns to IDLE.
REQ-007 lap  input  1  one-cycle pulse; freezes or unfreezes the display while counting continues.
REQ-008 digit_tenths  output  4  BCD tenths of a second, 0..9.
REQ-009 digit_sec_ones  output  4  BCD seconds ones, 0..9.
REQ-010 digit_sec_tens  output  4  BCD seconds tens, 0..5.
REQ-011 digit_min  output  4  BCD minutes, 0..MAX_MIN.
REQ-012 running  output  1  high in RUN and LAP.
REQ-013 lap_active  output  1  high in LAP.
REQ-014 overflow  output  1  sticky; high after the count saturates.

Function
REQ-015 The FSM SHALL have four states: IDLE, RUN, PAUSE and LAP.
REQ-016 IDLE: start_stop -> RUN; lap ignored; count held at 0.
REQ-017 RUN: start_stop -> PAUSE; lap -> LAP (latch the live count into the display register).
REQ-018 LAP: lap -> RUN (display returns to live); start_stop -> PAUSE, with the display showing the live count.
REQ-019 PAUSE: start_stop -> RUN; lap ignored; count held.
REQ-020 clear SHALL force IDLE, count 0 and overflow 0 from any state, with priority over start_stop, lap and tick in the same cycle.
REQ-021 The count SHALL advance by 0.1 s only on tick=1 while in RUN or LAP, including the cycle in which start_stop or lap is also asserted.
REQ-022 Carry chain: tenths 9->0 carries to sec_ones; sec_ones 9->0 carries to sec_tens; sec_tens 5->0 carries to min.
REQ-023 Saturation: a tick at MAX_MIN:59.9 SHALL hold the count at MAX_MIN:59.9, set overflow, and move to PAUSE.
REQ-024 While overflow=1, start_stop SHALL be ignored; only clear or reset exits.
REQ-025 Outputs are registered; a digit change caused by tick SHALL be visible on the cycle after the tick edge (latency 1).
REQ-026 The displayed digits SHALL equal the live count in every state except LAP, where they equal the latched value.
REQ-027 Simultaneous start_stop and lap SHALL be treated as start_stop only.
REQ-028 The digit registers SHALL never hold a non-BCD value or sec_tens > 5.

Reset
REQ-029 On reset=1 at a clock edge, the block SHALL enter IDLE with all digits 0, running=0, lap_active=0, overflow=0, and the lap latch at 0.
REQ-030 Reset asserted mid-count SHALL discard the count, and the next cycle SHALL be IDLE regardless of tick.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE/RUN/PAUSE/LAP), the BCD digit type (4 bits), and the constants TENTHS_MAX=9, SEC_ONES_MAX=9 and SEC_TENS_MAX=5.
REQ-032 One sub-module, bcd_digit_counter (parameter MAX; inputs clock, reset, clr, en; outputs q[3:0], carry), SHALL be instantiated four times in a ripple-enable chain.
REQ-033 carry SHALL be combinational: en && q==MAX.

Verification
REQ-034 reset, start_stop, 25 ticks -> digits 0:02.5, running=1.
REQ-035 Preload-by-ticks to 0:59.9, one tick -> 1:00.0, with all carries correct in one cycle.
REQ-036 RUN at 0:01.2, lap, 10 ticks -> display stays 0:01.2, lap_active=1; a second lap -> display 0:02.2.
REQ-037 RUN, start_stop and tick in the same cycle -> count +0.1 then PAUSE; further ticks leave digits unchanged.
REQ-038 MAX_MIN=1, run to 1:59.9, one tick -> digits 1:59.9, overflow=1, running=0; start_stop ignored; clear -> 0:00.0, overflow=0, IDLE.
REQ-039 clear, start_stop and tick in the same cycle while in RUN -> IDLE, 0:00.0; reset mid-LAP -> all outputs 0 the next cycle.
